// File: rtl/adder_tree_pipelined.sv
// Pipelined popcount tree for 1-bit bitstream lanes, with a valid pipe and
// a saturating, clearable running total of every valid count.
//
// Ports:
//   CLK          rising-edge clock
//   RST          asynchronous active-high reset
//   in_valid     qualifies inputs this cycle
//   inputs       NUM_INPUTS one-bit lanes to count
//   clear        synchronous clear of acc and acc_overflow
//   sum          popcount of a valid vector; holds while sum_valid is 0
//   sum_valid    sum is fresh this cycle
//   acc          saturating running total of valid sums
//   acc_overflow sticky saturation flag

module adder_tree_pipelined #(
    parameter int NUM_INPUTS = 32,
    parameter int REG_EVERY = 1,
    parameter int ACC_WIDTH = 16,
    localparam int SUM_W = $clog2(NUM_INPUTS + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  in_valid,
    input  logic [NUM_INPUTS-1:0] inputs,
    input  logic                  clear,
    output logic [SUM_W-1:0]      sum,
    output logic                  sum_valid,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  acc_overflow
);

    localparam int LEVELS = $clog2(NUM_INPUTS);
    localparam int P = 1 << LEVELS;
    localparam int RE = (REG_EVERY > 0) ? REG_EVERY : 1;

    if (NUM_INPUTS < 2) begin : g_bad_inputs
        $fatal(1, "adder_tree_pipelined: NUM_INPUTS must be >= 2");
    end
    if (ACC_WIDTH < SUM_W) begin : g_bad_acc
        $fatal(1, "adder_tree_pipelined: ACC_WIDTH must be >= SUM_W");
    end

    // Level 0 is the zero-padded lane vector; level k holds P>>k nodes of
    // k+1 bits, optionally registered together with its valid bit.
    for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
        logic [k:0] n [P>>k];
        logic       v;

        if (k == 0) begin : g_leaf
            for (genvar i = 0; i < P; i++) begin : g_lane
                if (i < NUM_INPUTS) begin : g_real
                    assign n[i] = inputs[i];
                end else begin : g_pad
                    assign n[i] = 1'b0;
                end
            end
            assign v = in_valid;
        end else begin : g_node
            localparam bit REG =
                (REG_EVERY > 0 && (k % RE) == 0) || k == LEVELS;
            logic [k:0] c [P>>k];

            for (genvar i = 0; i < (P >> k); i++) begin : g_add
                assign c[i] = {1'b0, g_lvl[k-1].n[2*i]}
                            + {1'b0, g_lvl[k-1].n[2*i+1]};
            end

            if (REG) begin : g_reg
                // Data loads only with an incoming valid so bubbles
                // leave the previous result in place.
                always_ff @(posedge CLK or posedge RST) begin
                    if (RST) begin
                        v <= 1'b0;
                        for (int i = 0; i < (P >> k); i++) begin
                            n[i] <= '0;
                        end
                    end else begin
                        v <= g_lvl[k-1].v;
                        if (g_lvl[k-1].v) begin
                            for (int i = 0; i < (P >> k); i++) begin
                                n[i] <= c[i];
                            end
                        end
                    end
                end
            end else begin : g_comb
                for (genvar i = 0; i < (P >> k); i++) begin : g_pass
                    assign n[i] = c[i];
                end
                assign v = g_lvl[k-1].v;
            end
        end
    end

    logic [LEVELS:0] top;
    assign top = g_lvl[LEVELS].n[0];

    // The root can be one bit wider than the largest possible count.
    if (LEVELS + 1 > SUM_W) begin : g_trim
        logic unused_msb;
        assign unused_msb = ^top[LEVELS:SUM_W];
    end

    assign sum = top[SUM_W-1:0];
    assign sum_valid = g_lvl[LEVELS].v;

    logic [ACC_WIDTH:0] acc_next;
    assign acc_next = {1'b0, acc} + (ACC_WIDTH + 1)'(sum);

    // A clear coinciding with a fresh sum restarts the total at that sum.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc <= '0;
            acc_overflow <= 1'b0;
        end else if (sum_valid) begin
            if (clear) begin
                acc <= ACC_WIDTH'(sum);
                acc_overflow <= 1'b0;
            end else if (acc_next[ACC_WIDTH]) begin
                acc <= '1;
                acc_overflow <= 1'b1;
            end else begin
                acc <= acc_next[ACC_WIDTH-1:0];
            end
        end else if (clear) begin
            acc <= '0;
            acc_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Scoreboard bench for adder_tree_pipelined: two configurations driven in
// parallel, expected counts and totals computed from plain arithmetic.

module tb_adder_tree_pipelined;

    typedef struct {
        int s;
        int due;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iv   [2];
    logic        clr  [2];
    logic [31:0] vec  [2];

    logic [5:0]  s0;
    logic [4:0]  s1;
    logic        sv0, sv1, o0, o1;
    logic [15:0] a0;
    logic [7:0]  a1;

    int   osum   [2];
    int   oacc   [2];
    logic ovalid [2];
    logic oovf   [2];

    int lens [2] = '{5, 3};
    int maxv [2] = '{65535, 255};
    int nin  [2] = '{32, 20};

    exp_t q     [2][$];
    int   macc  [2];
    bit   movf  [2];
    int   lasts [2];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t e;
    bit   here;

    adder_tree_pipelined #(
        .NUM_INPUTS(32), .REG_EVERY(1), .ACC_WIDTH(16)
    ) dut0 (
        .CLK(CLK), .RST(RST), .in_valid(iv[0]), .inputs(vec[0]),
        .clear(clr[0]), .sum(s0), .sum_valid(sv0), .acc(a0),
        .acc_overflow(o0)
    );

    adder_tree_pipelined #(
        .NUM_INPUTS(20), .REG_EVERY(2), .ACC_WIDTH(8)
    ) dut1 (
        .CLK(CLK), .RST(RST), .in_valid(iv[1]), .inputs(vec[1][19:0]),
        .clear(clr[1]), .sum(s1), .sum_valid(sv1), .acc(a1),
        .acc_overflow(o1)
    );

    assign osum[0] = 32'(s0);
    assign osum[1] = 32'(s1);
    assign oacc[0] = 32'(a0);
    assign oacc[1] = 32'(a1);
    assign ovalid[0] = sv0;
    assign ovalid[1] = sv1;
    assign oovf[0] = o0;
    assign oovf[1] = o1;

    always #5 CLK = ~CLK;

    task automatic chk(string nm, int d, int act, int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d",
                     nm, d, $time, act, expv);
        end
    endtask

    function automatic int cnt(int d);
        int c = 0;
        for (int i = 0; i < nin[d]; i++) c += int'(vec[d][i]);
        return c;
    endfunction

    task automatic chk_zero();
        for (int d = 0; d < 2; d++) begin
            chk("rst_sum", d, osum[d], 0);
            chk("rst_valid", d, int'(ovalid[d]), 0);
            chk("rst_acc", d, oacc[d], 0);
            chk("rst_ovf", d, int'(oovf[d]), 0);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(int n);
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        clr[0] = 1'b0;
        clr[1] = 1'b0;
        repeat (n) step();
    endtask

    // Expected count and arrival cycle for every accepted vector.
    always @(posedge CLK) begin
        cyc++;
        if (!RST) begin
            for (int d = 0; d < 2; d++) begin
                if (iv[d]) q[d].push_back('{s: cnt(d), due: cyc + lens[d] - 1});
            end
        end
    end

    always @(posedge RST) begin
        for (int d = 0; d < 2; d++) begin
            q[d].delete();
            macc[d] = 0;
            movf[d] = 1'b0;
            lasts[d] = 0;
        end
    end

    // Monitor: compare outputs, then advance the total model using the
    // clear that will be seen at the coming edge.
    always @(negedge CLK) begin
        if (!RST) begin
            for (int d = 0; d < 2; d++) begin
                chk("acc", d, oacc[d], macc[d]);
                chk("ovf", d, int'(oovf[d]), int'(movf[d]));
                here = q[d].size() > 0 && q[d][0].due == cyc;
                chk("valid", d, int'(ovalid[d]), int'(here));
                if (here) begin
                    e = q[d].pop_front();
                    chk("sum", d, osum[d], e.s);
                    lasts[d] = e.s;
                    if (clr[d]) begin
                        macc[d] = e.s;
                        movf[d] = 1'b0;
                    end else if (macc[d] + e.s > maxv[d]) begin
                        macc[d] = maxv[d];
                        movf[d] = 1'b1;
                    end else begin
                        macc[d] += e.s;
                    end
                end else begin
                    chk("hold", d, osum[d], lasts[d]);
                    if (clr[d]) begin
                        macc[d] = 0;
                        movf[d] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        int budget;
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0;
            clr[d] = 1'b0;
            vec[d] = '0;
            macc[d] = 0;
            movf[d] = 1'b0;
            lasts[d] = 0;
        end
        #12 chk_zero();
        #11 RST = 1'b0;
        step();

        // Single all-ones vector.
        vec[0] = 32'hFFFF_FFFF;
        iv[0] = 1'b1;
        step();
        idle(8);

        // Back-to-back vectors.
        vec[0] = 32'h0000_000F;
        iv[0] = 1'b1;
        step();
        vec[0] = 32'h00FF_00FF;
        step();
        vec[0] = 32'h8000_0001;
        step();
        idle(8);

        // Odd width: one full vector, then bubbles.
        vec[1] = 32'h000F_FFFF;
        iv[1] = 1'b1;
        step();
        idle(6);

        // Saturate the narrow total, then clear it.
        iv[1] = 1'b1;
        repeat (13) step();
        idle(5);
        clr[1] = 1'b1;
        step();
        idle(2);

        // Clear landing on the same edge as a fresh sum of 7.
        vec[0] = 32'h0000_007F;
        iv[0] = 1'b1;
        step();
        idle(4);
        clr[0] = 1'b1;
        step();
        idle(3);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            vec[0] = $urandom;
            vec[1] = $urandom & 32'h000F_FFFF;
            iv[0] = ($urandom_range(0, 9) < 7);
            iv[1] = ($urandom_range(0, 9) < 7);
            clr[0] = ($urandom_range(0, 19) == 0);
            clr[1] = ($urandom_range(0, 19) == 0);
            step();
        end
        idle(8);

        // Asynchronous reset in the middle of a burst.
        vec[0] = $urandom;
        vec[1] = $urandom & 32'h000F_FFFF;
        iv[0] = 1'b1;
        iv[1] = 1'b1;
        step();
        step();
        step();
        #1 RST = 1'b1;
        iv[0] = 1'b0;
        iv[1] = 1'b0;
        #1 chk_zero();
        #1 RST = 1'b0;
        idle(8);

        // Normal latency after release.
        vec[0] = 32'h0F0F_0F0F;
        vec[1] = 32'h0000_0F0F;
        iv[0] = 1'b1;
        iv[1] = 1'b1;
        step();
        idle(1);

        budget = 20;
        while ((q[0].size() > 0 || q[1].size() > 0) && budget > 0) begin
            step();
            budget--;
        end
        tests++;
        if (q[0].size() > 0 || q[1].size() > 0) begin
            fails++;
            $display("FAIL drain: got %0d/%0d pending expected 0",
                     q[0].size(), q[1].size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
